traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Phase sequencer for the two-street intersection. It owns the light state of street A and street B and the per-street countdowns that feed the 7-segment display path. It also generates its own 1 s tick from the system clock and supports a night flashing-yellow mode. It sits upstream of the countdown/display logic and drives the one-hot `street_a`/`street_b` light codes used throughout the design.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per 1 s tick; must be ≥ 2.
- `GREEN_S`, 45: green duration in ticks.
- `YELLOW_S`, 5: yellow duration in ticks.
- `ALLRED_S`, 2: all-red clearance duration in ticks.
- Constraint: each duration ≥ 1; `2*ALLRED_S+GREEN_S+YELLOW_S` ≤ 64.
- `clk` input 1: single clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset. It dominates every other input.
- `night` input 1: level request for flashing-yellow mode.
- `street_a` output 3: street A light, one-hot. 100 = red, 010 = yellow, 001 = green, 000 = dark (flash-off only).
- `street_b` output 3: street B light, same encoding.
- `count_a` output 6: seconds remaining in street A's current light, minus 1.
- `count_b` output 6: same for street B.
- `tick` output 1: one-cycle pulse marking each 1 s boundary.
- `phase` output 3: current state encoding (see Operation), for debug.

## Operation
- Tick divider: `div` counts 0..TICK_DIV-1 and wraps. `tick`=1 in the cycle when `div`==TICK_DIV-1.
- States and encodings: ALL_RED1 (0), A_GREEN (1), A_YELLOW (2), ALL_RED2 (3), B_GREEN (4), B_YELLOW (5), FLASH (6).
- Normal cycle: ALL_RED1 → A_GREEN → A_YELLOW → ALL_RED2 → B_GREEN → B_YELLOW → ALL_RED1.
- Light outputs per state:
  - ALL_RED1 and ALL_RED2: A=100, B=100.
  - A_GREEN: A=001, B=100.
  - A_YELLOW: A=010, B=100.
  - B_GREEN: A=100, B=001.
  - B_YELLOW: A=100, B=010.
- Phase timer: on entry it is loaded with (duration of the new state)-1. It decrements on each tick. On a tick with timer==0 the FSM advances, so each state lasts exactly its duration in ticks.
- Street counters:
  - When a street's light colour changes, its counter is loaded with the new colour's total duration minus 1. Otherwise it decrements on each tick.
  - Red duration is R = 2*ALLRED_S+GREEN_S+YELLOW_S, the same for both streets.
  - A red → green loads GREEN_S-1. Green → yellow loads YELLOW_S-1. Yellow → red loads R-1.
  - Colour changes occur only on ticks, so a counter never decrements below 0 before reload.
- Night mode:
  - `night` is sampled only on the advancing tick out of ALL_RED1 or ALL_RED2. If `night`=1 there, the next state is FLASH instead of the normal successor.
  - `night` is ignored in all other states, so green and yellow are never cut short.
  - FLASH: a flash bit toggles on every tick and is 0 on entry. Flash bit 0 gives A=B=000; flash bit 1 gives A=B=010. count_a = count_b = 0.
  - Exit: on the first tick with `night`=0, go to ALL_RED1 with the reset-time loads.
- Reset values (also applied on FLASH exit, except `div`):
  - state ALL_RED1; A=100; B=100.
  - timer = ALLRED_S-1; count_a = ALLRED_S-1; count_b = R-1.
  - `div` = 0; tick = 0; flash bit = 0.

## Timing
- All outputs are registered and change in the cycle after the `tick` cycle, or after the `rst` cycle.
- First tick after reset is TICK_DIV cycles after `rst` deasserts.
- `rst` mid-phase: the next edge restores reset values regardless of `night` or `div`.
- `rst` and `tick` in the same cycle: reset wins.
- `night` toggling between ticks has no effect. Only its value in the deciding tick cycle matters.
- A and B are never simultaneously non-red outside FLASH. This is a checked invariant.

## Test plan
Bench parameters: TICK_DIV=4, GREEN_S=3, YELLOW_S=2, ALLRED_S=1, so R=7.

- **Reset:** hold `rst` 2 cycles → A=B=100, count_a=0, count_b=6, phase=0. First `tick` appears 4 cycles after release.
- **Full cycle, night=0:**
  - Phase sequence 0,1,1,1,2,2,3,4,4,4,5,5, then back to 0, over 12 ticks.
  - count_a sequence 0,2,1,0,1,0,6,5,4,3,2,1, then 0.
  - count_b sequence 6,5,4,3,2,1,0,2,1,0,1,0, then 6.
- **Invariant:** random `night`/`rst` stimulus over 10k cycles → never (A≠100 and B≠100) outside phase 6. A one-hot or 000 check also holds on every output.
- **Night entry:**
  - Assert `night` during A_GREEN → the A_GREEN and A_YELLOW durations are unchanged. Flashing starts after ALL_RED2.
  - Flash outputs go 000, 010, 000, … per tick, with counts at 0.
- **Night exit:** drop `night` in FLASH → on the next tick phase=0 and A=B=100 with count_b=6. The normal cycle then resumes.
- **Mid-phase reset:** assert `rst` in B_YELLOW with `div`=2 → next cycle shows reset values. `tick` next fires 4 cycles after release.

Source files
------------

// File: rtl/traffic_phase_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : traffic_phase_ctrl_if                                       |
// | Purpose  : Bundles the phase sequencer's request and status signals.   |
// |            master = the sequencer, slave = display/countdown side.     |
// | Signals  : night     - level request for flashing-yellow mode          |
// |            street_a  - street A light, one-hot {red,yellow,green}      |
// |            street_b  - street B light, same encoding                   |
// |            count_a   - seconds left in A's current light, minus 1      |
// |            count_b   - seconds left in B's current light, minus 1      |
// |            tick      - one-cycle pulse on each 1 s boundary            |
// |            phase     - current sequencer state, for debug              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface traffic_phase_ctrl_if;
  logic       night;
  logic [2:0] street_a;
  logic [2:0] street_b;
  logic [5:0] count_a;
  logic [5:0] count_b;
  logic       tick;
  logic [2:0] phase;

  modport master (
    input  night,
    output street_a, street_b, count_a, count_b, tick, phase
  );

  modport slave (
    output night,
    input  street_a, street_b, count_a, count_b, tick, phase
  );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : traffic_phase_ctrl                                          |
// | Purpose  : Two-street intersection phase sequencer with a built-in     |
// |            1 s tick divider, per-street countdowns and a night         |
// |            flashing-yellow mode.                                       |
// | Ports    : clk  - system clock, rising edge                            |
// |            rst  - synchronous active-high reset, dominates all inputs  |
// |            bus  - traffic_phase_ctrl_if.master (night in; lights,      |
// |                   countdowns, tick and phase out)                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module traffic_phase_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int GREEN_S  = 45,
  parameter int YELLOW_S = 5,
  parameter int ALLRED_S = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  traffic_phase_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ALL_RED1 = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    ALL_RED2 = 3'd3,
    B_GREEN  = 3'd4,
    B_YELLOW = 3'd5,
    FLASH    = 3'd6
  } state_t;

  localparam int                 c_DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  // tick is registered, so it is armed one count early
  localparam logic [c_DIV_W-1:0] c_DIV_PRE  = c_DIV_W'(TICK_DIV - 2);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

  localparam int         c_RED_S  = 2*ALLRED_S + GREEN_S + YELLOW_S;
  localparam logic [5:0] c_RED_LD = 6'(c_RED_S - 1);
  localparam logic [5:0] c_GRN_LD = 6'(GREEN_S - 1);
  localparam logic [5:0] c_YEL_LD = 6'(YELLOW_S - 1);
  localparam logic [5:0] c_ARD_LD = 6'(ALLRED_S - 1);

  localparam logic [2:0] c_RED  = 3'b100;
  localparam logic [2:0] c_YEL  = 3'b010;
  localparam logic [2:0] c_GRN  = 3'b001;
  localparam logic [2:0] c_DARK = 3'b000;

  function automatic logic [2:0] f_light_a(input state_t s, input logic fb);
    case (s)
      A_GREEN:  return c_GRN;
      A_YELLOW: return c_YEL;
      FLASH:    return fb ? c_YEL : c_DARK;
      default:  return c_RED;
    endcase
  endfunction

  function automatic logic [2:0] f_light_b(input state_t s, input logic fb);
    case (s)
      B_GREEN:  return c_GRN;
      B_YELLOW: return c_YEL;
      FLASH:    return fb ? c_YEL : c_DARK;
      default:  return c_RED;
    endcase
  endfunction

  // Street counter reload for a freshly shown colour
  function automatic logic [5:0] f_colour_ld(input logic [2:0] l);
    case (l)
      c_GRN:   return c_GRN_LD;
      c_YEL:   return c_YEL_LD;
      default: return c_RED_LD;
    endcase
  endfunction

  // Phase timer reload on state entry
  function automatic logic [5:0] f_state_ld(input state_t s);
    case (s)
      ALL_RED1, ALL_RED2: return c_ARD_LD;
      A_GREEN,  B_GREEN:  return c_GRN_LD;
      A_YELLOW, B_YELLOW: return c_YEL_LD;
      default:            return 6'd0;
    endcase
  endfunction

  function automatic state_t f_succ(input state_t s);
    case (s)
      ALL_RED1: return A_GREEN;
      A_GREEN:  return A_YELLOW;
      A_YELLOW: return ALL_RED2;
      ALL_RED2: return B_GREEN;
      B_GREEN:  return B_YELLOW;
      default:  return ALL_RED1;
    endcase
  endfunction

  logic [c_DIV_W-1:0] r_div;
  logic               r_tick;
  state_t             r_state;
  logic               r_flash;
  logic [5:0]         r_timer;
  logic [5:0]         r_cnt_a;
  logic [5:0]         r_cnt_b;

  state_t             w_state_nxt;
  logic               w_flash_nxt;
  logic [5:0]         w_timer_nxt;
  logic [5:0]         w_cnt_a_nxt;
  logic [5:0]         w_cnt_b_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_state <= ALL_RED1;
      r_flash <= 1'b0;
      r_timer <= c_ARD_LD;
      r_cnt_a <= c_ARD_LD;
      r_cnt_b <= c_RED_LD;
    end else begin
      r_div   <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_ONE;
      r_tick  <= (r_div == c_DIV_PRE);
      r_state <= w_state_nxt;
      r_flash <= w_flash_nxt;
      r_timer <= w_timer_nxt;
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_flash_nxt = r_flash;
    w_timer_nxt = r_timer;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    if (r_tick) begin
      if (r_state == FLASH) begin
        if (bus.night) begin
          w_flash_nxt = ~r_flash;
        end else begin
          // Leave flashing through the same point reset starts from
          w_state_nxt = ALL_RED1;
          w_flash_nxt = 1'b0;
          w_timer_nxt = c_ARD_LD;
          w_cnt_a_nxt = c_ARD_LD;
          w_cnt_b_nxt = c_RED_LD;
        end
      end else begin
        if (r_timer == 6'd0) begin
          // Night is only honoured at the end of an all-red clearance,
          // so green and yellow always run their full length.
          if (bus.night && (r_state == ALL_RED1 || r_state == ALL_RED2)) begin
            w_state_nxt = FLASH;
          end else begin
            w_state_nxt = f_succ(r_state);
          end
          w_timer_nxt = f_state_ld(w_state_nxt);
        end else begin
          w_timer_nxt = r_timer - 6'd1;
        end

        if (w_state_nxt == FLASH) begin
          w_cnt_a_nxt = 6'd0;
          w_cnt_b_nxt = 6'd0;
        end else begin
          // A counter reloads only when its street's colour changes
          if (f_light_a(w_state_nxt, 1'b0) != f_light_a(r_state, 1'b0)) begin
            w_cnt_a_nxt = f_colour_ld(f_light_a(w_state_nxt, 1'b0));
          end else begin
            w_cnt_a_nxt = r_cnt_a - 6'd1;
          end
          if (f_light_b(w_state_nxt, 1'b0) != f_light_b(r_state, 1'b0)) begin
            w_cnt_b_nxt = f_colour_ld(f_light_b(w_state_nxt, 1'b0));
          end else begin
            w_cnt_b_nxt = r_cnt_b - 6'd1;
          end
        end
      end
    end
  end

  assign bus.street_a = f_light_a(r_state, r_flash);
  assign bus.street_b = f_light_b(r_state, r_flash);
  assign bus.count_a  = r_cnt_a;
  assign bus.count_b  = r_cnt_b;
  assign bus.tick     = r_tick;
  assign bus.phase    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_traffic_phase_ctrl                                       |
// | Purpose  : Self-checking bench for traffic_phase_ctrl. A schedule-     |
// |            position model predicts every output each cycle; directed   |
// |            literal expectations pin the model to hand-derived values.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_traffic_phase_ctrl;

  localparam int TD = 4;
  localparam int G  = 3;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int R  = 2*AR + G + Y;
  localparam int C  = 2*(AR + G + Y);   // ticks in one full normal cycle

  logic clk = 1'b0;
  logic rst = 1'b1;

  traffic_phase_ctrl_if bus ();

  traffic_phase_ctrl #(
    .TICK_DIV (TD),
    .GREEN_S  (G),
    .YELLOW_S (Y),
    .ALLRED_S (AR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- schedule model ----------------
  // m_pos is the tick position inside the 12-tick normal cycle, 0 = start
  // of ALL_RED1. Lights, phase and countdowns all follow from it.
  int m_div = 0;
  int m_pos = 0;
  bit m_fl  = 1'b0;
  bit m_fb  = 1'b0;

  function automatic int col_a(input int p);
    if (p < AR)         return 4;
    if (p < AR + G)     return 1;
    if (p < AR + G + Y) return 2;
    return 4;
  endfunction

  // B runs the same schedule shifted by half a cycle
  function automatic int col_b(input int p);
    return col_a((p + C - (AR + G + Y)) % C);
  endfunction

  function automatic int rem_a(input int p);
    int k = 1;
    while (k < C && col_a((p + k) % C) == col_a(p)) k++;
    return k - 1;
  endfunction

  function automatic int rem_b(input int p);
    int k = 1;
    while (k < C && col_b((p + k) % C) == col_b(p)) k++;
    return k - 1;
  endfunction

  function automatic int phase_of(input int p);
    if (p < AR)               return 0;
    if (p < AR + G)           return 1;
    if (p < AR + G + Y)       return 2;
    if (p < 2*AR + G + Y)     return 3;
    if (p < 2*AR + 2*G + Y)   return 4;
    return 5;
  endfunction

  always @(posedge clk) begin : model
    bit was_tick;
    was_tick = (m_div == TD - 1);
    if (rst) begin
      m_div = 0; m_pos = 0; m_fl = 1'b0; m_fb = 1'b0;
    end else begin
      if (was_tick) begin
        if (m_fl) begin
          if (bus.night) m_fb = ~m_fb;
          else begin m_fl = 1'b0; m_fb = 1'b0; m_pos = 0; end
        end else if (bus.night && (m_pos == AR - 1 || m_pos == 2*AR + G + Y - 1)) begin
          m_fl = 1'b1; m_fb = 1'b0;
        end else begin
          m_pos = (m_pos + 1) % C;
        end
      end
      m_div = (m_div + 1) % TD;
    end
  end

  always @(negedge clk) begin : compare
    int ea, eb;
    if (chk_en) begin
      ea = m_fl ? (m_fb ? 2 : 0) : col_a(m_pos);
      eb = m_fl ? (m_fb ? 2 : 0) : col_b(m_pos);
      check("m_tick",    int'(bus.tick),     (m_div == TD - 1) ? 1 : 0);
      check("m_phase",   int'(bus.phase),    m_fl ? 6 : phase_of(m_pos));
      check("m_street_a", int'(bus.street_a), ea);
      check("m_street_b", int'(bus.street_b), eb);
      check("m_count_a", int'(bus.count_a),  m_fl ? 0 : rem_a(m_pos));
      check("m_count_b", int'(bus.count_b),  m_fl ? 0 : rem_b(m_pos));
      check("onehot0_a", int'($onehot0(bus.street_a)), 1);
      check("onehot0_b", int'($onehot0(bus.street_b)), 1);
      if (bus.phase != 3'd6)
        check("both_non_red", int'(bus.street_a != 3'b100 && bus.street_b != 3'b100), 0);
    end
  end

  // ---------------- directed stimulus ----------------
  int ph [13] = '{0, 1, 1, 1, 2, 2, 3, 4, 4, 4, 5, 5, 0};
  int ca [13] = '{0, 2, 1, 0, 1, 0, 6, 5, 4, 3, 2, 1, 0};
  int cb [13] = '{6, 5, 4, 3, 2, 1, 0, 2, 1, 0, 1, 0, 6};
  int la [13] = '{4, 1, 1, 1, 2, 2, 4, 4, 4, 4, 4, 4, 4};
  int lb [13] = '{4, 4, 4, 4, 4, 4, 4, 1, 1, 1, 2, 2, 4};
  int ne [6]  = '{1, 1, 2, 2, 3, 6};

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Step to the tick cycle, then through the edge that applies it
  task automatic next_tick();
    int n = 0;
    while (bus.tick !== 1'b1 && n < 4*TD) begin cyc(); n++; end
    check("tick_wait", int'(bus.tick), 1);
    cyc();
  endtask

  task automatic check_state(input string tag, input int p, input int a, input int b,
                             input int xa, input int xb);
    check({tag, "_phase"},    int'(bus.phase),    p);
    check({tag, "_street_a"}, int'(bus.street_a), a);
    check({tag, "_street_b"}, int'(bus.street_b), b);
    check({tag, "_count_a"},  int'(bus.count_a),  xa);
    check({tag, "_count_b"},  int'(bus.count_b),  xb);
  endtask

  initial begin
    int n;
    bus.night = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    chk_en = 1'b1;
    check_state("reset", 0, 4, 4, 0, 6);
    check("reset_tick", int'(bus.tick), 0);
    rst = 1'b0;

    // div runs 0,1,2,3 after release: tick sits in the fourth cycle
    n = 0;
    while (bus.tick !== 1'b1 && n < 20) begin cyc(); n++; end
    check("first_tick_latency", n, 3);

    for (int k = 0; k < 13; k++) begin
      if (k > 0) next_tick();
      check_state($sformatf("cycle%0d", k), ph[k], la[k], lb[k], ca[k], cb[k]);
    end

    // Night requested in A_GREEN: green/yellow keep their length
    next_tick();
    check("night_agreen_phase", int'(bus.phase), 1);
    bus.night = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_tick();
      check($sformatf("night_entry%0d_phase", k), int'(bus.phase), ne[k]);
    end
    check_state("flash0", 6, 0, 0, 0, 0);
    next_tick();
    check_state("flash1", 6, 2, 2, 0, 0);
    next_tick();
    check_state("flash2", 6, 0, 0, 0, 0);

    bus.night = 1'b0;
    next_tick();
    check_state("night_exit", 0, 4, 4, 0, 6);
    next_tick();
    check_state("resume", 1, 1, 4, 2, 5);

    // Reset in B_YELLOW with div=2
    n = 0;
    while (bus.phase != 3'd5 && n < 20) begin next_tick(); n++; end
    check("reach_b_yellow", int'(bus.phase), 5);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check_state("mid_reset", 0, 4, 4, 0, 6);
    check("mid_reset_tick", int'(bus.tick), 0);
    rst = 1'b0;

    // A night pulse between ticks must be ignored
    n = 0;
    while (bus.tick !== 1'b1 && n < 20) begin
      cyc(); n++;
      if (n == 1) bus.night = 1'b1;
      if (n == 2) bus.night = 1'b0;
    end
    check("mid_reset_tick_latency", n, 3);
    cyc();
    check("night_glitch_ignored", int'(bus.phase), 1);

    // Random night/rst soak, checked by the compare process
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if ($urandom_range(0, 63) == 0) bus.night = ~bus.night;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
